axi4_lite_master_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4-Lite master engine between NUM_REQ local requesters. It sits between requester blocks and the local command interface of the master read/write state machines (USR_ENA/USR_WSTB/USR_ADDR/USR_WDATA in, USR_DONE/USR_RDATA/USR_RESP back). It latches one requester's command, issues it downstream as a single-cycle USR_ENA, waits for completion, and returns data, response and a single-cycle acknowledge to the winner.

---
 rtl/axi4_lite_master_arbiter_if.sv | 47 ++++
 rtl/axi4_lite_master_arbiter.sv | 152 +++++++++++++++
 tb/tb_axi4_lite_master_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_master_arbiter_if.sv
// Bundle of requester-side and master-engine-side signals for axi4_lite_master_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the
// surrounding requesters and master engine.
interface axi4_lite_master_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ_ENA;
    logic [NUM_REQ*STRB_W-1:0]     REQ_WSTB;
    logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA;
    logic [NUM_REQ-1:0]            REQ_ACK;
    logic [DATA_WIDTH-1:0]         REQ_RDATA;
    logic [1:0]                    REQ_RESP;

    logic                          USR_ENA;
    logic [STRB_W-1:0]             USR_WSTB;
    logic [ADDR_WIDTH-1:0]         USR_ADDR;
    logic [DATA_WIDTH-1:0]         USR_WDATA;
    logic                          USR_DONE;
    logic [DATA_WIDTH-1:0]         USR_RDATA;
    logic [1:0]                    USR_RESP;

    logic                          BUSY;
    logic [IDX_W-1:0]              GRANT_IDX;
    logic                          TIMEOUT;

    modport slave (
        input  REQ_ENA, REQ_WSTB, REQ_ADDR, REQ_WDATA,
        input  USR_DONE, USR_RDATA, USR_RESP,
        output REQ_ACK, REQ_RDATA, REQ_RESP,
        output USR_ENA, USR_WSTB, USR_ADDR, USR_WDATA,
        output BUSY, GRANT_IDX, TIMEOUT
    );

    modport master (
        output REQ_ENA, REQ_WSTB, REQ_ADDR, REQ_WDATA,
        output USR_DONE, USR_RDATA, USR_RESP,
        input  REQ_ACK, REQ_RDATA, REQ_RESP,
        input  USR_ENA, USR_WSTB, USR_ADDR, USR_WDATA,
        input  BUSY, GRANT_IDX, TIMEOUT
    );
endinterface

// File: rtl/axi4_lite_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master engine between NUM_REQ requesters.
// One command is latched, issued as a single-cycle USR_ENA, and its completion is
// returned to the winner as a single-cycle REQ_ACK with data and response.
// Optional completion watchdog: define AXI4_LITE_MASTER_ARBITER_TIMEOUT_EN.
module axi4_lite_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                      ACLK,
    input logic                      ARESETn,
    axi4_lite_master_arbiter_if.slave bus
);
    localparam int          STRB_W = DATA_WIDTH / 8;
    localparam int          IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

    state_t                  state, next_state;
    logic [IDX_W-1:0]        grant, last_grant, sel_idx;
    logic                    sel_found;
    int unsigned             cand;
    logic [STRB_W-1:0]       wstb_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;
    logic                    wd_hit;

    logic [STRB_W-1:0]       req_wstb_a  [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   req_addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   req_wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_wstb_a[g]  = bus.REQ_WSTB[g*STRB_W +: STRB_W];
        assign req_addr_a[g]  = bus.REQ_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_wdata_a[g] = bus.REQ_WDATA[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pick the first active requester above the last winner, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= NREQ_U; i++) begin
            cand = 32'(last_grant) + i;
            if (cand >= NREQ_U) begin
                cand = cand - NREQ_U;
            end
            if (!sel_found && bus.REQ_ENA[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (sel_found) next_state = ISSUE;
            ISSUE:     next_state = WAIT_DONE;
            WAIT_DONE: if (bus.USR_DONE || wd_hit) next_state = RESPOND;
            RESPOND:   next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Command latch at grant, response capture on completion, fairness pointer update.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            grant      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            wstb_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            resp_q     <= '0;
        end else begin
            if (state == IDLE && sel_found) begin
                grant   <= sel_idx;
                wstb_q  <= req_wstb_a[sel_idx];
                addr_q  <= req_addr_a[sel_idx];
                wdata_q <= req_wdata_a[sel_idx];
            end
            if (state == WAIT_DONE) begin
                if (bus.USR_DONE) begin
                    rdata_q <= bus.USR_RDATA;
                    resp_q  <= bus.USR_RESP;
                end else if (wd_hit) begin
                    rdata_q <= '0;
                    resp_q  <= 2'b10;
                end
            end
            if (state == RESPOND) begin
                last_grant <= grant;
            end
        end
    end

`ifdef AXI4_LITE_MASTER_ARBITER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    // The limit is reached on the increment that would make the count equal TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_q;

    assign wd_hit = (state == WAIT_DONE) && !bus.USR_DONE && (wd_cnt == WD_LAST);

    // Watchdog counter and the one-cycle TIMEOUT pulse aligned with RESPOND.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_hit;
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT_DONE && !bus.USR_DONE) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    assign bus.TIMEOUT = timeout_q;
`else
    assign wd_hit      = 1'b0;
    assign bus.TIMEOUT = 1'b0;
`endif

    assign bus.USR_ENA   = (state == ISSUE);
    assign bus.USR_WSTB  = wstb_q;
    assign bus.USR_ADDR  = addr_q;
    assign bus.USR_WDATA = wdata_q;
    assign bus.BUSY      = (state != IDLE);
    assign bus.GRANT_IDX = grant;
    assign bus.REQ_ACK   = (state == RESPOND) ? (NUM_REQ'(1) << grant) : '0;
    assign bus.REQ_RDATA = rdata_q;
    assign bus.REQ_RESP  = resp_q;
endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Directed bench for axi4_lite_master_arbiter with a scoreboard of expected
// transactions and a small master-engine model answering USR_ENA.
module tb_axi4_lite_master_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi4_lite_master_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_master_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(aclk),
        .ARESETn(aresetn),
        .bus(bus)
    );

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [3:0]  wstb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] addr;
        logic [3:0]  wstb;
        logic [31:0] wdata;
    } cmd_t;

    exp_t exp_q[$];
    cmd_t obs_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit eng_en = 1'b1;
    int eng_delay = 2;
    int kick_req = 0;
    int kick_ack = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return a ^ 32'hDEADBEFF;
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[3:2];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master engine model: records every issued command and answers after eng_delay cycles.
    initial begin : engine
        bit pend;
        int left;
        pend = 1'b0;
        left = 0;
        bus.USR_DONE  = 1'b0;
        bus.USR_RDATA = '0;
        bus.USR_RESP  = '0;
        forever begin
            @(posedge aclk);
            cyc++;
            #1;
            bus.USR_DONE = 1'b0;
            if (pend) begin
                if (left <= 1) begin
                    bus.USR_DONE  = 1'b1;
                    bus.USR_RDATA = mem_rd(bus.USR_ADDR);
                    bus.USR_RESP  = resp_of(bus.USR_ADDR);
                    pend = 1'b0;
                end else begin
                    left--;
                end
            end
            if (kick_req != kick_ack) begin
                kick_ack++;
                bus.USR_DONE  = 1'b1;
                bus.USR_RDATA = mem_rd(bus.USR_ADDR);
                bus.USR_RESP  = resp_of(bus.USR_ADDR);
            end
            if (bus.USR_ENA) begin
                obs_q.push_back('{cyc: cyc, idx: int'(bus.GRANT_IDX), addr: bus.USR_ADDR,
                                  wstb: bus.USR_WSTB, wdata: bus.USR_WDATA});
                if (eng_en) begin
                    pend = 1'b1;
                    left = eng_delay;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] wstb, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.REQ_WSTB[i*SW +: SW]  = wstb;
        bus.REQ_ADDR[i*AW +: AW]  = addr;
        bus.REQ_WDATA[i*DW +: DW] = wdata;
    endtask

    task automatic push_exp(input int i, input logic [3:0] wstb, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic [1:0] resp);
        exp_q.push_back('{idx: i, addr: addr, wstb: wstb, wdata: wdata, rdata: rdata, resp: resp});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"},   64'(bus.REQ_ACK),   64'd0);
        chk({tag, "_rdata"}, 64'(bus.REQ_RDATA), 64'd0);
        chk({tag, "_resp"},  64'(bus.REQ_RESP),  64'd0);
        chk({tag, "_uena"},  64'(bus.USR_ENA),   64'd0);
        chk({tag, "_uwstb"}, 64'(bus.USR_WSTB),  64'd0);
        chk({tag, "_uaddr"}, 64'(bus.USR_ADDR),  64'd0);
        chk({tag, "_uwdat"}, 64'(bus.USR_WDATA), 64'd0);
        chk({tag, "_busy"},  64'(bus.BUSY),      64'd0);
        chk({tag, "_grant"}, 64'(bus.GRANT_IDX), 64'd0);
        chk({tag, "_tmo"},   64'(bus.TIMEOUT),   64'd0);
    endtask

    // Wait (bounded) for the next REQ_ACK, score it and the command that produced it.
    task automatic txn(input string tag, input bit drop, output int ack_cyc,
                       output int cmd_cyc, output logic to);
        logic [3:0] ack;
        exp_t e;
        cmd_t c;
        ack = '0;
        ack_cyc = -1;
        cmd_cyc = -1;
        to = 1'b0;
        for (int k = 0; k < 200 && ack == 4'b0000; k++) begin
            @(negedge aclk);
            if (bus.REQ_ACK != '0) begin
                ack = bus.REQ_ACK;
                ack_cyc = cyc;
                to = bus.TIMEOUT;
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = '{idx: 0, addr: '0, wstb: '0, wdata: '0, rdata: '0, resp: '0};
        end
        chk({tag, "_ack"},   64'(ack), 64'(1) << e.idx);
        chk({tag, "_rdata"}, 64'(bus.REQ_RDATA), 64'(e.rdata));
        chk({tag, "_resp"},  64'(bus.REQ_RESP),  64'(e.resp));
        if (drop) begin
            bus.REQ_ENA = bus.REQ_ENA & ~ack;
        end
        chk({tag, "_cmd_seen"}, 64'(obs_q.size() > 0), 64'd1);
        if (obs_q.size() > 0) begin
            c = obs_q.pop_front();
            cmd_cyc = c.cyc;
            chk({tag, "_grant"}, 64'(c.idx),   64'(e.idx));
            chk({tag, "_addr"},  64'(c.addr),  64'(e.addr));
            chk({tag, "_wstb"},  64'(c.wstb),  64'(e.wstb));
            chk({tag, "_wdata"}, 64'(c.wdata), 64'(e.wdata));
        end
    endtask

    initial begin : main
        int ack_c;
        int cmd_c;
        int prev_c;
        logic to;
        logic [3:0] ack_acc;
        bus.REQ_ENA   = '0;
        bus.REQ_WSTB  = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;

        // Reset state
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check_zero("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        // Single read from requester 0, engine answers two cycles after USR_ENA
        set_req(0, 4'h0, 32'h10, 32'h5555AAAA);
        push_exp(0, 4'h0, 32'h10, 32'h5555AAAA, 32'hDEADBEEF, 2'b00);
        bus.REQ_ENA[0] = 1'b1;
        @(posedge aclk);
        #1;
        chk("rd_usr_ena_c1", 64'(bus.USR_ENA), 64'd1);
        chk("rd_busy_c1", 64'(bus.BUSY), 64'd1);
        txn("rd", 1'b1, ack_c, cmd_c, to);
        chk("rd_latency", 64'(ack_c - cmd_c), 64'd3);
        repeat (2) @(negedge aclk);
        chk("rd_addr_hold", 64'(bus.USR_ADDR), 64'h10);
        chk("rd_idle_busy", 64'(bus.BUSY), 64'd0);

        // Write from requester 2; its inputs change after the grant and must be ignored
        set_req(2, 4'hF, 32'h40, 32'h12345678);
        push_exp(2, 4'hF, 32'h40, 32'h12345678, mem_rd(32'h40), resp_of(32'h40));
        bus.REQ_ENA[2] = 1'b1;
        @(negedge aclk);
        set_req(2, 4'h3, 32'h44, 32'hFFFF0000);
        txn("wr", 1'b1, ack_c, cmd_c, to);
        repeat (2) @(negedge aclk);
        chk("wr_grant_hold", 64'(bus.GRANT_IDX), 64'd2);
        chk("wr_wdata_hold", 64'(bus.USR_WDATA), 64'h12345678);

        // Round-robin with all four requesting and a zero-wait engine
        aresetn = 1'b0;
        @(negedge aclk);
        chk("rr_rst_grant", 64'(bus.GRANT_IDX), 64'd0);
        aresetn = 1'b1;
        eng_delay = 1;
        for (int i = 0; i < NR; i++) begin
            set_req(i, (i % 2 == 1) ? 4'hF : 4'h0, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            push_exp(i, (i % 2 == 1) ? 4'hF : 4'h0, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i),
                     mem_rd(32'h100 + 32'(4 * i)), resp_of(32'h100 + 32'(4 * i)));
        end
        bus.REQ_ENA = '1;
        prev_c = -1;
        for (int i = 0; i < NR; i++) begin
            txn($sformatf("rr%0d", i), 1'b1, ack_c, cmd_c, to);
            if (i > 0) chk($sformatf("rr%0d_spacing", i), 64'(cmd_c - prev_c), 64'd4);
            prev_c = cmd_c;
        end
        repeat (8) @(negedge aclk);
        chk("rr_extra_cmds", 64'(obs_q.size()), 64'd0);
        chk("rr_busy_end", 64'(bus.BUSY), 64'd0);

        // Fairness: requesters 0 and 1 keep requesting
        eng_delay = 2;
        set_req(0, 4'h1, 32'h20, 32'h0000_0A0A);
        set_req(1, 4'h0, 32'h24, 32'h0000_0B0B);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_exp(0, 4'h1, 32'h20, 32'h0A0A, mem_rd(32'h20), resp_of(32'h20));
            else            push_exp(1, 4'h0, 32'h24, 32'h0B0B, mem_rd(32'h24), resp_of(32'h24));
        end
        bus.REQ_ENA = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            txn($sformatf("fair%0d", i), 1'b0, ack_c, cmd_c, to);
        end
        bus.REQ_ENA = '0;
        repeat (6) @(negedge aclk);
        chk("fair_extra_cmds", 64'(obs_q.size()), 64'd0);

        // Reset in the middle of WAIT_DONE, then a late USR_DONE
        eng_en = 1'b0;
        set_req(3, 4'h0, 32'h200, 32'h0);
        bus.REQ_ENA[3] = 1'b1;
        for (int k = 0; k < 50 && !bus.USR_ENA; k++) @(negedge aclk);
        chk("mid_issue", 64'(bus.USR_ENA), 64'd1);
        repeat (2) @(negedge aclk);
        bus.REQ_ENA = '0;
        aresetn = 1'b0;
        @(negedge aclk);
        check_zero("mid_rst");
        aresetn = 1'b1;
        kick_req++;
        ack_acc = '0;
        repeat (8) begin
            @(negedge aclk);
            ack_acc = ack_acc | bus.REQ_ACK;
        end
        chk("mid_no_ack", 64'(ack_acc), 64'd0);
        check_zero("mid_after");
        obs_q.delete();
        eng_en = 1'b1;
        set_req(1, 4'h0, 32'h30, 32'h0);
        set_req(3, 4'hC, 32'h38, 32'h0303_0303);
        push_exp(1, 4'h0, 32'h30, 32'h0, mem_rd(32'h30), resp_of(32'h30));
        push_exp(3, 4'hC, 32'h38, 32'h0303_0303, mem_rd(32'h38), resp_of(32'h38));
        bus.REQ_ENA = 4'b1010;
        txn("post_rst_a", 1'b1, ack_c, cmd_c, to);
        txn("post_rst_b", 1'b1, ack_c, cmd_c, to);

`ifdef AXI4_LITE_MASTER_ARBITER_TIMEOUT_EN
        // Watchdog fires with no USR_DONE
        eng_en = 1'b0;
        set_req(0, 4'h0, 32'h300, 32'h0);
        push_exp(0, 4'h0, 32'h300, 32'h0, 32'h0, 2'b10);
        bus.REQ_ENA[0] = 1'b1;
        txn("wd", 1'b1, ack_c, cmd_c, to);
        chk("wd_latency", 64'(ack_c - cmd_c), 64'd9);
        chk("wd_timeout", 64'(to), 64'd1);
        @(negedge aclk);
        chk("wd_timeout_pulse", 64'(bus.TIMEOUT), 64'd0);
        // USR_DONE arriving in the limit cycle wins over the watchdog
        eng_en = 1'b1;
        eng_delay = TO;
        set_req(2, 4'h0, 32'h304, 32'h0);
        push_exp(2, 4'h0, 32'h304, 32'h0, mem_rd(32'h304), resp_of(32'h304));
        bus.REQ_ENA[2] = 1'b1;
        txn("wd_edge", 1'b1, ack_c, cmd_c, to);
        chk("wd_edge_latency", 64'(ack_c - cmd_c), 64'd9);
        chk("wd_edge_timeout", 64'(to), 64'd0);
`else
        // Without the watchdog a silent engine leaves the arbiter waiting
        eng_en = 1'b0;
        set_req(0, 4'h0, 32'h300, 32'h0);
        push_exp(0, 4'h0, 32'h300, 32'h0, mem_rd(32'h300), resp_of(32'h300));
        bus.REQ_ENA[0] = 1'b1;
        ack_acc = '0;
        to = 1'b0;
        repeat (40) begin
            @(negedge aclk);
            ack_acc = ack_acc | bus.REQ_ACK;
            to = to | bus.TIMEOUT;
        end
        chk("nowd_no_ack", 64'(ack_acc), 64'd0);
        chk("nowd_no_timeout", 64'(to), 64'd0);
        chk("nowd_busy", 64'(bus.BUSY), 64'd1);
        kick_req++;
        txn("nowd", 1'b1, ack_c, cmd_c, to);
        chk("nowd_timeout_at_ack", 64'(to), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
